// File: rtl/bcd_arb_pkg.sv
// Shared definitions for the BCD converter arbiter: state encoding, default
// sizing constants and the channel-index width helper.
package bcd_arb_pkg;

  localparam int DEF_NUM_CH  = 4;
  localparam int DEF_BIN_W   = 32;
  localparam int DEF_BCD_W   = 40;
  localparam int DEF_TIMEOUT = 48;

  // One-hot, matching the converter-side state style.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_ISSUE = 4'b0010,
    ST_WAIT  = 4'b0100,
    ST_RESP  = 4'b1000
  } arb_state_t;

  function automatic int ch_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after the
// pointer, wrapping modulo NUM_CH.
module rr_pick #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [CH_W-1:0]   i_ptr,
  output logic [NUM_CH-1:0] o_grant,
  output logic [CH_W-1:0]   o_idx,
  output logic              o_any
);

  always_comb begin
    int w_c;
    w_c     = 0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    // Walk from the farthest offset down so the nearest one to i_ptr wins.
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      w_c = int'(i_ptr) + k;
      if (w_c >= NUM_CH) w_c = w_c - NUM_CH;
      if (|(i_req & (NUM_CH'(1) << w_c))) begin
        o_grant = NUM_CH'(1) << w_c;
        o_idx   = CH_W'(w_c);
        o_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one serial binary-to-BCD converter; one
// conversion outstanding, watchdog-guarded, results tagged with channel ID.
module bcd_conv_arbiter
  import bcd_arb_pkg::*;
#(
  parameter  int NUM_CH  = DEF_NUM_CH,
  parameter  int BIN_W   = DEF_BIN_W,
  parameter  int BCD_W   = DEF_BCD_W,
  parameter  int TIMEOUT = DEF_TIMEOUT,
  localparam int CH_W    = ch_w(NUM_CH)
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [NUM_CH-1:0]       req,
  input  logic [NUM_CH*BIN_W-1:0] req_data,
  output logic [NUM_CH-1:0]       req_ack,
  output logic                    conv_start,
  output logic [BIN_W-1:0]        conv_bin,
  input  logic                    conv_bcd_vld,
  input  logic [BCD_W-1:0]        conv_bcd,
  output logic                    res_vld,
  input  logic                    res_rdy,
  output logic [CH_W-1:0]         res_ch,
  output logic [BCD_W-1:0]        res_bcd,
  output logic                    timeout_err,
  output logic                    busy,
  output logic [3:0]              dbg_state
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  arb_state_t        r_state, w_next;
  logic [CH_W-1:0]   r_ptr, r_ch, r_res_ch;
  logic [BIN_W-1:0]  r_bin;
  logic [BCD_W-1:0]  r_res_bcd;
  logic [WD_W-1:0]   r_wdog;
  logic [NUM_CH-1:0] w_grant;
  logic [CH_W-1:0]   w_idx;
  logic              w_any;
  logic              w_expired;

  rr_pick #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_expired = (r_wdog == WD_W'(TIMEOUT - 1));

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Result port: a beat transfers on a cycle where res_vld and res_rdy are
  // both high; res_ch/res_bcd hold steady while res_vld waits for res_rdy.
  always_comb begin
    w_next      = r_state;
    req_ack     = '0;
    conv_start  = 1'b0;
    timeout_err = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any && !Rst) begin
          req_ack = w_grant;
          w_next  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        conv_start = 1'b1;
        w_next     = ST_WAIT;
      end
      ST_WAIT: begin
        // A strobe arriving on the expiry cycle still delivers its result.
        if (conv_bcd_vld) begin
          w_next = ST_RESP;
        end else if (w_expired) begin
          timeout_err = 1'b1;
          w_next      = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (res_rdy) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_ptr     <= '0;
      r_ch      <= '0;
      r_bin     <= '0;
      r_res_ch  <= '0;
      r_res_bcd <= '0;
      r_wdog    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_bin <= req_data[w_idx*BIN_W +: BIN_W];
            r_ch  <= w_idx;
            r_ptr <= (w_idx == CH_W'(NUM_CH - 1)) ? '0 : w_idx + 1'b1;
          end
        end
        ST_ISSUE: r_wdog <= '0;
        ST_WAIT: begin
          r_wdog <= r_wdog + 1'b1;
          if (conv_bcd_vld) begin
            r_res_bcd <= conv_bcd;
            r_res_ch  <= r_ch;
          end
        end
        default: ;
      endcase
    end
  end

  assign conv_bin  = r_bin;
  assign res_vld   = (r_state == ST_RESP);
  assign res_ch    = r_res_ch;
  assign res_bcd   = r_res_bcd;
  assign busy      = (r_state != ST_IDLE);
  assign dbg_state = r_state;

endmodule
